// File: rtl/ring_vc_input_port.sv
// ---------------------------------------------------------------------------
// ring_vc_input_port
//
// Per-direction router input stage with NUM_VC virtual channels. Each VC has
// its own DEPTH-entry FIFO. The head flit of every non-empty VC raises a
// request towards either the local PE output (hop field == 0) or the forward
// ring output (hop field != 0). On the forward path the hop field of the
// presented flit is already decremented by one.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid        upstream offers a flit this cycle
//   in_vc           target VC of the offered flit (>= NUM_VC is illegal)
//   in_data         offered flit
//   in_ready        combinational; FIFO[in_vc] has a free entry this cycle
//   req_fwd[v]      VC v head wants the forward ring output
//   req_pe[v]       VC v head wants the local PE output
//   grant_fwd[v]    forward arbiter grant for VC v
//   grant_pe[v]     PE arbiter grant for VC v
//   data_out        head flit of VC v at [v*DATA_WIDTH +: DATA_WIDTH]
//   occupancy       per-VC entry count, $clog2(DEPTH+1) bits per VC
//   stat_flits      saturating accepted-flit counter
//
// Optional feature macro: RING_VC_INPUT_STATS_EN
//   defined   -> stat_flits counts accepted pushes, saturating at 16'hFFFF
//   undefined -> stat_flits is tied to zero and no counter exists
// ---------------------------------------------------------------------------
module ring_vc_input_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 2,
  parameter int HOP_LSB    = 48,
  parameter int HOP_W      = 8,
  parameter int VC_W       = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [VC_W-1:0]                       in_vc,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  in_ready,
  output logic [NUM_VC-1:0]                     req_fwd,
  output logic [NUM_VC-1:0]                     req_pe,
  input  logic [NUM_VC-1:0]                     grant_fwd,
  input  logic [NUM_VC-1:0]                     grant_pe,
  output logic [NUM_VC*DATA_WIDTH-1:0]          data_out,
  output logic [NUM_VC*$clog2(DEPTH+1)-1:0]     occupancy,
  output logic [15:0]                           stat_flits
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage and per-VC bookkeeping
  logic [DATA_WIDTH-1:0] mem_q     [NUM_VC][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d     [NUM_VC][DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q  [NUM_VC];
  logic [PTR_W-1:0]      rd_ptr_d  [NUM_VC];
  logic [PTR_W-1:0]      wr_ptr_q  [NUM_VC];
  logic [PTR_W-1:0]      wr_ptr_d  [NUM_VC];
  logic [CNT_W-1:0]      count_q   [NUM_VC];
  logic [CNT_W-1:0]      count_d   [NUM_VC];
  // Last presented head per VC, so data_out holds its value once a VC drains
  logic [DATA_WIDTH-1:0] last_q    [NUM_VC];
  logic [DATA_WIDTH-1:0] last_d    [NUM_VC];

  logic [DATA_WIDTH-1:0] head      [NUM_VC];
  logic [DATA_WIDTH-1:0] head_out  [NUM_VC];
  logic [NUM_VC-1:0]     non_empty;
  logic [NUM_VC-1:0]     hop_zero;
  logic [NUM_VC-1:0]     pop;
  logic [NUM_VC-1:0]     push_sel;

  // Pointer increment with wrap from DEPTH-1 back to 0 (DEPTH need not be a
  // power of two, so the natural binary overflow cannot be relied on).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Head decode: request direction, presented flit and pop qualification.
  // A grant only pops when it matches the output the head is requesting,
  // which also makes grants to empty VCs harmless.
  always_comb begin
    req_fwd   = '0;
    req_pe    = '0;
    pop       = '0;
    non_empty = '0;
    hop_zero  = '0;
    data_out  = '0;
    occupancy = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      head[v]      = mem_q[v][rd_ptr_q[v]];
      non_empty[v] = (count_q[v] != '0);
      hop_zero[v]  = (head[v][HOP_LSB +: HOP_W] == '0);
      head_out[v]  = head[v];
      if (!hop_zero[v]) begin
        head_out[v][HOP_LSB +: HOP_W] = head[v][HOP_LSB +: HOP_W] - HOP_W'(1);
      end
      req_fwd[v] = non_empty[v] & ~hop_zero[v];
      req_pe[v]  = non_empty[v] &  hop_zero[v];
      pop[v]     = (grant_fwd[v] & req_fwd[v]) | (grant_pe[v] & req_pe[v]);
      data_out[v*DATA_WIDTH +: DATA_WIDTH] = non_empty[v] ? head_out[v] : last_q[v];
      occupancy[v*CNT_W +: CNT_W] = count_q[v];
    end
  end

  // Input acceptance looks only at the current count, so a full FIFO stays
  // not-ready even when it is popped in the same cycle. An out-of-range
  // in_vc matches no VC and therefore leaves in_ready low.
  always_comb begin
    in_ready = 1'b0;
    push_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (in_vc == VC_W'(v)) begin
        in_ready    = (count_q[v] < CNT_W'(DEPTH));
        push_sel[v] = in_valid & (count_q[v] < CNT_W'(DEPTH));
      end
    end
  end

  // Next-state for storage, pointers, counts and the held head value.
  always_comb begin
    mem_d = mem_q;
    for (int v = 0; v < NUM_VC; v++) begin
      rd_ptr_d[v] = rd_ptr_q[v];
      wr_ptr_d[v] = wr_ptr_q[v];
      count_d[v]  = count_q[v];
      last_d[v]   = non_empty[v] ? head_out[v] : last_q[v];
      if (push_sel[v]) begin
        mem_d[v][wr_ptr_q[v]] = in_data;
        wr_ptr_d[v]           = ptr_inc(wr_ptr_q[v]);
      end
      if (pop[v]) begin
        rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
      end
      case ({push_sel[v], pop[v]})
        2'b10:   count_d[v] = count_q[v] + CNT_W'(1);
        2'b01:   count_d[v] = count_q[v] - CNT_W'(1);
        default: count_d[v] = count_q[v];
      endcase
    end
  end

  // Control state; reset empties every VC and drops any grant of that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        count_q[v]  <= '0;
        last_q[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        rd_ptr_q[v] <= rd_ptr_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        count_q[v]  <= count_d[v];
        last_q[v]   <= last_d[v];
      end
    end
  end

  // Flit storage needs no reset: an entry is only observed once written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef RING_VC_INPUT_STATS_EN
  logic [15:0] stat_flits_q;
  logic [15:0] stat_flits_d;

  // Saturating count of accepted pushes across all VCs
  always_comb begin
    stat_flits_d = stat_flits_q;
    if ((|push_sel) && (stat_flits_q != 16'hFFFF)) begin
      stat_flits_d = stat_flits_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits_q <= '0;
    end else begin
      stat_flits_q <= stat_flits_d;
    end
  end

  assign stat_flits = stat_flits_q;
`else
  assign stat_flits = '0;
`endif

endmodule

// File: tb/tb_ring_vc_input_port.sv
// ---------------------------------------------------------------------------
// tb_ring_vc_input_port
//
// Self-checking bench for ring_vc_input_port with default parameters.
// A table of hand-derived vectors walks through the directed scenarios,
// followed by a stats sequence and a long randomized run. Every cycle all
// outputs are also compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ring_vc_input_port;

  localparam int DW      = 64;
  localparam int NV      = 2;
  localparam int DEPTH   = 2;
  localparam int HOP_LSB = 48;
  localparam int HOP_W   = 8;
  localparam int VC_W    = 1;
  localparam int CW      = 2;

  localparam logic [63:0] FA  = 64'h00AA_0000_0000_0001;
  localparam logic [63:0] FAD = 64'h00A9_0000_0000_0001;
  localparam logic [63:0] FB  = 64'h0000_0000_0000_0055;
  localparam logic [63:0] FC  = 64'h0003_0000_0000_00C1;
  localparam logic [63:0] FCD = 64'h0002_0000_0000_00C1;
  localparam logic [63:0] FD  = 64'h0002_0000_0000_00D2;
  localparam logic [63:0] FDD = 64'h0001_0000_0000_00D2;
  localparam logic [63:0] FE  = 64'h0001_0000_0000_00E3;
  localparam logic [63:0] FF  = 64'h0000_0000_0000_0077;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [VC_W-1:0]    in_vc;
  logic [DW-1:0]      in_data;
  logic               in_ready;
  logic [NV-1:0]      req_fwd;
  logic [NV-1:0]      req_pe;
  logic [NV-1:0]      grant_fwd;
  logic [NV-1:0]      grant_pe;
  logic [NV*DW-1:0]   data_out;
  logic [NV*CW-1:0]   occupancy;
  logic [15:0]        stat_flits;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  // Reference model: one queue per VC, plus last presented head and stats
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] last_exp[NV];
  int          stat_exp;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [0:0]  vc;
    logic [63:0] data;
    logic [1:0]  gf;
    logic [1:0]  gp;
    logic        e_rdy;
    logic [1:0]  e_fwd;
    logic [1:0]  e_pe;
    logic [3:0]  e_occ;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
  } vec_t;

  vec_t vecs[$];

  ring_vc_input_port #(
    .DATA_WIDTH(DW), .NUM_VC(NV), .DEPTH(DEPTH),
    .HOP_LSB(HOP_LSB), .HOP_W(HOP_W), .VC_W(VC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vc(in_vc), .in_data(in_data), .in_ready(in_ready),
    .req_fwd(req_fwd), .req_pe(req_pe),
    .grant_fwd(grant_fwd), .grant_pe(grant_pe),
    .data_out(data_out), .occupancy(occupancy), .stat_flits(stat_flits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flit as it should appear at the output: hop field reduced by one
  // (mod 2**HOP_W) when non-zero, otherwise unchanged.
  function automatic logic [63:0] shown(input logic [63:0] f);
    logic [63:0] r;
    int hop;
    r   = f;
    hop = int'(f[HOP_LSB +: HOP_W]);
    if (hop != 0) r[HOP_LSB +: HOP_W] = HOP_W'((hop - 1) % (1 << HOP_W));
    return r;
  endfunction

  function automatic int msize(input int v);
    return (v == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [63:0] mhead(input int v);
    return (v == 0) ? q0[0] : q1[0];
  endfunction

  function automatic logic [63:0] exp_data(input int v);
    return (msize(v) != 0) ? shown(mhead(v)) : last_exp[v];
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the reference model
  task automatic checkOutput();
    logic [63:0] e_stat;
    logic exp_rdy;
    if (!check_en) return;
    exp_rdy = (int'(in_vc) < NV) && (msize(int'(in_vc)) < DEPTH);
    checkValue("in_ready", 64'(in_ready), 64'(exp_rdy));
    for (int v = 0; v < NV; v++) begin
      logic e_f;
      logic e_p;
      e_f = 1'b0;
      e_p = 1'b0;
      if (msize(v) != 0) begin
        if (mhead(v)[HOP_LSB +: HOP_W] == 0) e_p = 1'b1;
        else e_f = 1'b1;
      end
      checkValue($sformatf("model req_fwd[%0d]", v), 64'(req_fwd[v]), 64'(e_f));
      checkValue($sformatf("model req_pe[%0d]", v), 64'(req_pe[v]), 64'(e_p));
      checkValue($sformatf("model occupancy[%0d]", v), 64'(occupancy[v*CW +: CW]), 64'(msize(v)));
      checkValue($sformatf("model data_out[%0d]", v), data_out[v*DW +: DW], exp_data(v));
    end
`ifdef RING_VC_INPUT_STATS_EN
    e_stat = 64'(stat_exp);
`else
    e_stat = 64'd0;
`endif
    checkValue("model stat_flits", 64'(stat_flits), e_stat);
  endtask

  // Drive one cycle of inputs away from the active edge, then check
  task automatic applyStimulus(input logic r, input logic v, input logic [0:0] vc,
                               input logic [63:0] d, input logic [1:0] gf, input logic [1:0] gp);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_vc     = vc;
    in_data   = d;
    grant_fwd = gf;
    grant_pe  = gp;
    #1;
    checkOutput();
  endtask

  // Clock edge: advance the reference model with the inputs just applied
  task automatic advanceClock();
    logic pop_m[NV];
    logic do_push;
    int   tv;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int v = 0; v < NV; v++) last_exp[v] = '0;
      stat_exp = 0;
    end else begin
      tv      = int'(in_vc);
      do_push = in_valid && (tv < NV) && (msize(tv) < DEPTH);
      for (int v = 0; v < NV; v++) begin
        pop_m[v] = 1'b0;
        if (msize(v) != 0) begin
          last_exp[v] = shown(mhead(v));
          pop_m[v] = (mhead(v)[HOP_LSB +: HOP_W] == 0) ? grant_pe[v] : grant_fwd[v];
        end
      end
      if (pop_m[0]) void'(q0.pop_front());
      if (pop_m[1]) void'(q1.pop_front());
      if (do_push) begin
        if (tv == 0) q0.push_back(in_data);
        else q1.push_back(in_data);
        if (stat_exp < 65535) stat_exp++;
      end
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic [63:0] e_stat;
    rst = 1'b1; in_valid = 1'b0; in_vc = '0; in_data = '0; grant_fwd = '0; grant_pe = '0;
    stat_exp = 0;
    for (int v = 0; v < NV; v++) last_exp[v] = '0;

    // Directed vectors: inputs of the row, outputs expected before its edge
    vecs.push_back('{1'b0, 1'b1, 1'b0, FA,    2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 64'd0, 64'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FAD,   64'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, FB,    2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FAD,   64'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 64'd0, 2'b00, 2'b10, 1'b1, 2'b01, 2'b10, 4'b0101, FAD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 64'd0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FAD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b01, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FAD,   FB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, FC,    2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, FAD,   FB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, FD,    2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FCD,   FB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, FE,    2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0010, FCD,   FB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, FE,    2'b01, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0010, FCD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FDD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b01, 2'b00, 1'b1, 2'b01, 2'b00, 4'b0001, FDD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, FDD,   FB});
    vecs.push_back('{1'b0, 1'b1, 1'b0, FF,    2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, FDD,   FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b01, 2'b10, 1'b1, 2'b00, 2'b01, 4'b0001, FF,    FB});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 4'b0001, FF,    FB});
    vecs.push_back('{1'b0, 1'b1, 1'b1, FA,    2'b00, 2'b00, 1'b1, 2'b00, 2'b01, 4'b0001, FF,    FB});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 64'd0, 2'b00, 2'b01, 1'b1, 2'b10, 2'b01, 4'b0101, FF,    FAD});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 4'b0000, 64'd0, 64'd0});

    // Initial reset; the model is not compared until state is defined
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00);
    advanceClock();
    check_en = 1'b1;
    $display("[TB] directed vectors");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].vc, vecs[i].data, vecs[i].gf, vecs[i].gp);
      checkValue($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      checkValue($sformatf("vec%0d req_fwd", i), 64'(req_fwd), 64'(vecs[i].e_fwd));
      checkValue($sformatf("vec%0d req_pe", i), 64'(req_pe), 64'(vecs[i].e_pe));
      checkValue($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
      checkValue($sformatf("vec%0d data_out0", i), data_out[DW-1:0], vecs[i].e_d0);
      checkValue($sformatf("vec%0d data_out1", i), data_out[2*DW-1:DW], vecs[i].e_d1);
      advanceClock();
    end

    // Five accepted pushes at full rate into VC0 while it is drained
    $display("[TB] stats sequence");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 64'(k + 1), 2'b00, 2'b01);
      advanceClock();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b01);
`ifdef RING_VC_INPUT_STATS_EN
    e_stat = 64'd5;
`else
    e_stat = 64'd0;
`endif
    checkValue("stat_flits after 5 pushes", 64'(stat_flits), e_stat);
    advanceClock();
    applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00);
    advanceClock();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 2'b00);
    checkValue("stat_flits after reset", 64'(stat_flits), 64'd0);
    advanceClock();

    // Randomized traffic against the reference model
    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic       v;
      logic [0:0] vc;
      logic [1:0] gf;
      logic [1:0] gp;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 3) != 0);
      vc = 1'($urandom_range(0, 1));
      gf = 2'($urandom_range(0, 3));
      gp = 2'($urandom_range(0, 3));
      rd = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0, 1:    rd[HOP_LSB +: HOP_W] = '0;
        2:       rd[HOP_LSB +: HOP_W] = 8'd1;
        default: ;
      endcase
      applyStimulus(r, v, vc, rd, gf, gp);
      advanceClock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_vc_input_port.md
Name: ring_vc_input_port

Overview:
- Parametrised successor of the router's per-direction input stage.
- Generalises the fixed two-VC (even/odd), single-slot input buffer to NUM_VC virtual channels, each with a DEPTH-entry FIFO.
- Routes each head flit by its hop field: hop==0 requests the local PE output, otherwise the forward ring output with hop decremented.
- Sits between the upstream link (valid/ready handshake) and the output-port arbiters (per-VC request/grant).

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- NUM_VC, 2, number of virtual channels (>=1).
- DEPTH, 2, FIFO entries per VC (>=1; need not be a power of 2).
- HOP_LSB, 48, LSB of hop field.
- HOP_W, 8, hop field width; field is [HOP_LSB+HOP_W-1:HOP_LSB].
- VC_W, 1, width of in_vc; must satisfy 2**VC_W >= NUM_VC.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream offers a flit this cycle.
- in_vc  in  VC_W  target VC of the offered flit; values >= NUM_VC are illegal.
- in_data  in  DATA_WIDTH  offered flit.
- in_ready  out  1  combinational; 1 iff FIFO[in_vc] count < DEPTH.
- req_fwd  out  NUM_VC  bit v: VC v head valid and hop != 0.
- req_pe  out  NUM_VC  bit v: VC v head valid and hop == 0.
- grant_fwd  in  NUM_VC  forward arbiter grant per VC.
- grant_pe  in  NUM_VC  PE arbiter grant per VC.
- data_out  out  NUM_VC*DATA_WIDTH  head flit of VC v at slice [v*DATA_WIDTH +: DATA_WIDTH].
- occupancy  out  NUM_VC*$clog2(DEPTH+1)  per-VC entry count.
- stat_flits  out  16  accepted-flit counter (see Optional Feature).

Behaviour:
- Reset values: all FIFOs empty, all pointers and counts 0, req_fwd = req_pe = 0, data_out = 0, occupancy = 0, stat_flits = 0.
- Reset asserted mid-operation discards all stored flits on that posedge. Grants in that cycle are ignored.
- Push: when in_valid & in_ready at posedge, in_data is written to FIFO[in_vc] at its write pointer and count increments.
- in_ready is evaluated on the current count only. A full FIFO is not ready even if a pop occurs in the same cycle; there is no bypass.
- in_valid with in_vc >= NUM_VC: in_ready = 0 and nothing is written.
- Request (combinational from head state): for each VC v with count != 0, head hop == 0 gives req_pe[v] = 1, else req_fwd[v] = 1. Exactly one is set per non-empty VC; both are 0 when empty.
- data_out slice v when hop == 0: the head flit unchanged.
- data_out slice v when hop != 0: the head flit with its hop field decremented by 1, modulo 2**HOP_W. No other bits change.
- data_out slice v when the VC is empty: holds the last head value. Not meaningful when req = 0.
- Pop: at posedge, VC v pops when (grant_fwd[v] & req_fwd[v]) | (grant_pe[v] & req_pe[v]). The read pointer advances and count decrements.
- A grant on the non-requesting output, or any grant to an empty VC, is ignored.
- Pointers wrap from DEPTH-1 to 0.
- Simultaneous push and pop on the same VC: count is unchanged and both pointers advance.
- Push into an empty VC: the flit becomes head and its request asserts the next cycle. Minimum latency from push to request is 1 cycle.
- Latency from grant to the next head is 1 cycle. A VC can sustain 1 flit/cycle when DEPTH >= 2.
- VCs are fully independent. No ordering holds across VCs; FIFO order holds within a VC.

Optional Feature:
- Macro: RING_VC_INPUT_STATS_EN.
- Defined: stat_flits increments on every accepted push and saturates at 16'hFFFF. It is cleared by rst.
- Undefined: stat_flits is tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset, then push flit 64'h00AA_0000_0000_0001 on VC0 → after 1 cycle req_fwd=2'b01, data_out[63:0]=64'h00A9_0000_0000_0001, occupancy VC0=1.
- Push hop-0 flit 64'h0000_0000_0000_0055 on VC1, grant_pe[1] the next cycle → req_pe[1] drops the cycle after the grant, occupancy VC1 returns to 0.
- DEPTH=2: push 3 flits to VC0 with no grants → in_ready=0 on the 3rd push attempt, 3rd flit not stored; grant once → in_ready=1 next cycle.
- Full VC0 with simultaneous push and grant → push rejected, pop performed, count 2→1; order preserved across 4 wrap-around transfers.
- Assert grant_fwd[0] while VC0 holds a hop-0 flit, and grant_pe[1] while VC1 is empty → no pop, no state change.
- Assert rst while both VCs are holding flits → all requests 0 and occupancy 0 next cycle. With RING_VC_INPUT_STATS_EN, 5 pushes give stat_flits=5, and reset returns it to 0.
